read_bank_mux: RTL and testbench

//  Read-side consumer of the accounter's bank_select for one read agent. Accepts read

---
 rtl/meduram_pkg.sv | 9 +
 rtl/rdresp_fifo.sv | 47 ++++
 rtl/read_bank_mux.sv | 116 +++++++++++
 tb/tb_read_bank_mux.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/meduram_pkg.sv
// Shared helpers for the memory read/write accounting blocks.
package meduram_pkg;

  // Width of the accounter's bank_select: owner index plus optional collision flag.
  function automatic int sel_width(input int nb_wragent, input int write_collision);
    return ((nb_wragent == 1) ? 1 : $clog2(nb_wragent)) + write_collision;
  endfunction

endpackage

// File: rtl/rdresp_fifo.sv
// Synchronous result buffer; head is presented combinationally, zero when empty.
module rdresp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_eff, pop_eff;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign push_eff = push_i && !full_o;
  assign pop_eff  = pop_i && !empty_o;
  assign dout_o   = empty_o ? '0 : mem_q[rd_ptr_q];

  // NOTE: storage is deliberately not reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_ptr_q] <= din_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_eff)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_eff) - (AW+1)'(pop_eff);
    end
  end

endmodule

// File: rtl/read_bank_mux.sv
// Read agent front end: issues reads to all banks, pipelines the accounter select
// alongside RAM latency, muxes the owning bank and buffers results under credit control.
module read_bank_mux
  import meduram_pkg::*;
#(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int NB_WRAGENT      = 2,
  parameter int WRITE_COLLISION = 1,
  parameter int SELECT_WIDTH    = sel_width(NB_WRAGENT, WRITE_COLLISION),
  parameter int RAM_LATENCY     = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic                             rden,
  output logic                             rdready,
  input  logic [ADDR_WIDTH-1:0]            rdaddr,
  output logic [ADDR_WIDTH-1:0]            acc_rdaddr,
  input  logic [SELECT_WIDTH-1:0]          acc_select,
  output logic                             bank_rden,
  output logic [ADDR_WIDTH-1:0]            bank_rdaddr,
  input  logic [NB_WRAGENT*DATA_WIDTH-1:0] bank_rddata,
  output logic                             rdvalid,
  input  logic                             rdresp_ready,
  output logic [DATA_WIDTH-1:0]            rddata,
  output logic                             rdcollision
);

  localparam int IDX_W = SELECT_WIDTH - WRITE_COLLISION;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic                  collision;
    logic [DATA_WIDTH-1:0] data;
  } rdresp_t;

  logic                                     acc, pop, push;
  logic [OCC_W-1:0]                         occ_q, occ_d;
  logic                                     rdready_q, rdready_d;
  logic [RAM_LATENCY-1:0]                   vld_q;
  logic [RAM_LATENCY-1:0][SELECT_WIDTH-1:0] sel_q;
  logic [IDX_W-1:0]                         idx;
  logic                                     sel_coll;
  logic                                     fifo_empty, fifo_full;
  rdresp_t                                  push_rec, head_rec;

  assign rdready     = rdready_q;
  assign acc         = rden && rdready_q;
  assign bank_rden   = acc;
  assign bank_rdaddr = rdaddr;
  assign acc_rdaddr  = rdaddr;
  assign pop         = rdvalid && rdresp_ready;
  assign push        = vld_q[RAM_LATENCY-1];

  // Credit covers both in-flight reads and buffered results, so the FIFO can never overflow.
  always_comb begin
    occ_d     = occ_q + OCC_W'(acc) - OCC_W'(pop);
    rdready_d = (occ_d < OCC_W'(FIFO_DEPTH));
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      occ_q     <= '0;
      rdready_q <= 1'b0;
      vld_q     <= '0;
      sel_q     <= '0;
    end else begin
      occ_q     <= occ_d;
      rdready_q <= rdready_d;
      vld_q[0]  <= acc;
      sel_q[0]  <= acc_select;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        sel_q[i] <= sel_q[i-1];
      end
    end
  end

  if (WRITE_COLLISION != 0) begin : g_coll
    assign sel_coll = sel_q[RAM_LATENCY-1][SELECT_WIDTH-1];
  end else begin : g_nocoll
    assign sel_coll = 1'b0;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    push_rec           = '0;
    idx                = sel_q[RAM_LATENCY-1][IDX_W-1:0];
    push_rec.collision = sel_coll;
    if (int'(idx) < NB_WRAGENT) begin
      push_rec.data = bank_rddata[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  rdresp_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (push),
    .din_i   (push_rec),
    .pop_i   (pop),
    .dout_o  (head_rec),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign rdvalid     = !fifo_empty;
  assign rddata      = head_rec.data;
  assign rdcollision = head_rec.collision;

  a_no_overflow : assert property (@(posedge aclk) disable iff (areset) !(push && fifo_full));

endmodule

// File: tb/tb_read_bank_mux.sv
// Directed bench for read_bank_mux: a 2-bank and a 3-bank instance share request stimulus.
module tb_read_bank_mux;

  logic        aclk   = 1'b0;
  logic        areset = 1'b1;
  logic        rden   = 1'b1;
  logic [7:0]  rdaddr = '0;
  logic        rdresp_ready = 1'b1;

  logic        rdready2, bank_rden2, rdvalid2, rdcoll2;
  logic [7:0]  acc_rdaddr2, bank_rdaddr2;
  logic [1:0]  acc_select2 = '0;
  logic [63:0] bank_rddata2 = '0;
  logic [31:0] rddata2;

  logic        rdready3, bank_rden3, rdvalid3, rdcoll3;
  logic [7:0]  acc_rdaddr3, bank_rdaddr3;
  logic [2:0]  acc_select3 = '0;
  logic [95:0] bank_rddata3 = '0;
  logic [31:0] rddata3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  read_bank_mux #(.NB_WRAGENT(2)) dut2 (
    .aclk(aclk), .areset(areset), .rden(rden), .rdready(rdready2), .rdaddr(rdaddr),
    .acc_rdaddr(acc_rdaddr2), .acc_select(acc_select2), .bank_rden(bank_rden2),
    .bank_rdaddr(bank_rdaddr2), .bank_rddata(bank_rddata2), .rdvalid(rdvalid2),
    .rdresp_ready(rdresp_ready), .rddata(rddata2), .rdcollision(rdcoll2)
  );

  read_bank_mux #(.NB_WRAGENT(3)) dut3 (
    .aclk(aclk), .areset(areset), .rden(rden), .rdready(rdready3), .rdaddr(rdaddr),
    .acc_rdaddr(acc_rdaddr3), .acc_select(acc_select3), .bank_rden(bank_rden3),
    .bank_rdaddr(bank_rdaddr3), .bank_rddata(bank_rddata3), .rdvalid(rdvalid3),
    .rdresp_ready(rdresp_ready), .rddata(rddata3), .rdcollision(rdcoll3)
  );

  // Bank contents: {0xB, bank, 0x5A5A, addr}, except bank1 row 0x10 holds 0xCAFE0001.
  function automatic logic [31:0] bank_word(input int b, input logic [7:0] a);
    if (b == 1 && a == 8'h10) return 32'hCAFE0001;
    return {4'hB, 4'(b), 16'h5A5A, a};
  endfunction

  always @(posedge aclk) begin
    if (bank_rden2) for (int b = 0; b < 2; b++) bank_rddata2[b*32 +: 32] <= bank_word(b, bank_rdaddr2);
    if (bank_rden3) for (int b = 0; b < 3; b++) bank_rddata3[b*32 +: 32] <= bank_word(b, bank_rdaddr3);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nedge();
    @(negedge aclk);
  endtask

  int          n_acc;
  int          spurious;
  logic [31:0] exp4 [4];

  initial begin
    // 1: reset holds everything idle even with rden asserted
    nedge();
    check("rst_rdready", rdready2, 0);
    check("rst_bank_rden", bank_rden2, 0);
    check("rst_rdvalid", rdvalid2, 0);
    check("rst_rddata", rddata2, 0);
    check("rst_rdcoll", rdcoll2, 0);
    areset = 1'b0;
    rden   = 1'b0;
    nedge();
    check("post_rst_rdready", rdready2, 1);

    // 2: owner bank1, no collision, latency T+2
    rden = 1'b1; rdaddr = 8'h10; acc_select2 = 2'b01; acc_select3 = 3'b001;
    #1;
    check("t2_bank_rden", bank_rden2, 1);
    check("t2_bank_rdaddr", bank_rdaddr2, 32'h10);
    check("t2_acc_rdaddr", acc_rdaddr2, 32'h10);
    nedge();
    rden = 1'b0;
    check("t2_no_early_valid", rdvalid2, 0);
    nedge();
    check("t2_rdvalid", rdvalid2, 1);
    check("t2_rddata", rddata2, 32'hCAFE0001);
    check("t2_rdcoll", rdcoll2, 0);
    nedge();
    check("t2_popped", rdvalid2, 0);

    // 3: collision flag with bank0 ownership
    rden = 1'b1; rdaddr = 8'h11; acc_select2 = 2'b10;
    nedge();
    rden = 1'b0;
    nedge();
    check("t3_rdvalid", rdvalid2, 1);
    check("t3_rddata", rddata2, 32'hB05A5A11);
    check("t3_rdcoll", rdcoll2, 1);
    nedge();

    // 4: consumer stalled, credit limits acceptance to FIFO_DEPTH
    rdresp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      rden = 1'b1; rdaddr = 8'h20 + 8'(i); acc_select2 = {1'b0, 1'(i)};
      #1;
      if (rdready2) n_acc++;
      nedge();
    end
    rden = 1'b0;
    check("t4_accepts", n_acc, 4);
    check("t4_rdready_low", rdready2, 0);
    exp4[0] = 32'hB05A5A20; exp4[1] = 32'hB15A5A21;
    exp4[2] = 32'hB05A5A22; exp4[3] = 32'hB15A5A23;
    check("t4_rdvalid", rdvalid2, 1);
    check("t4_data0", rddata2, exp4[0]);
    rdresp_ready = 1'b1;
    nedge();
    check("t4_rdready_back", rdready2, 1);
    check("t4_data1", rddata2, exp4[1]);
    nedge();
    check("t4_data2", rddata2, exp4[2]);
    nedge();
    check("t4_data3", rddata2, exp4[3]);
    nedge();
    check("t4_drained", rdvalid2, 0);

    // 5: 3 banks, index 3 out of range reads 0; index 2 with collision reads bank2
    rden = 1'b1; rdaddr = 8'h30; acc_select2 = 2'b00; acc_select3 = 3'b011;
    nedge();
    rdaddr = 8'h31; acc_select3 = 3'b110;
    nedge();
    rden = 1'b0;
    check("t5_rdvalid", rdvalid3, 1);
    check("t5_oob_data", rddata3, 0);
    check("t5_oob_coll", rdcoll3, 0);
    nedge();
    check("t5_b2_data", rddata3, 32'hB25A5A31);
    check("t5_b2_coll", rdcoll3, 1);
    nedge();

    // 6: reset with one buffered and one in-flight read discards both
    rden = 1'b1; rdaddr = 8'h40; acc_select2 = 2'b01;
    nedge();
    rdaddr = 8'h41; acc_select2 = 2'b00;
    nedge();
    rden = 1'b0;
    areset = 1'b1;
    #1;
    check("t6_rst_rdvalid", rdvalid2, 0);
    check("t6_rst_rdready", rdready2, 0);
    nedge();
    areset = 1'b0;
    spurious = 0;
    for (int i = 0; i < 6; i++) begin
      nedge();
      if (rdvalid2 || rdvalid3) spurious++;
    end
    check("t6_no_stale_resp", spurious, 0);
    rden = 1'b1; rdaddr = 8'h42; acc_select2 = 2'b01;
    nedge();
    rden = 1'b0;
    nedge();
    check("t6_next_valid", rdvalid2, 1);
    check("t6_next_data", rddata2, 32'hB15A5A42);
    nedge();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
